mmu_dma_region_arbiter: RTL and testbench

- Shared-DMA arbitration stage directly downstream of the per-vFPGA MMU region tops.
- Collects translated host-DMA requests from N_REGIONS regions and forwards them, round-robin, onto a single host-DMA request channel.
- Records the granted region ID of every forwarded request in an in-order tag FIFO.
- Routes each in-order DMA completion back to the originating region.

---
 rtl/mmu_dma_region_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mmu_dma_region_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mmu_dma_region_arbiter.sv
// Round-robin arbiter merging per-region MMU DMA requests onto one channel.
// Optional packet locking is enabled by defining ARB_PACKET_LOCK_EN.
module mmu_dma_region_arbiter #(
  parameter int N_REGIONS     = 4,
  parameter int PADDR_W       = 64,
  parameter int LEN_W         = 28,
  parameter int N_OUTSTANDING = 16,
  localparam int ID_W  = $clog2(N_REGIONS),
  localparam int CNT_W = $clog2(N_OUTSTANDING) + 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_REGIONS-1:0]         s_req_valid,
  output logic [N_REGIONS-1:0]         s_req_ready,
  input  logic [N_REGIONS*PADDR_W-1:0] s_req_paddr,
  input  logic [N_REGIONS*LEN_W-1:0]   s_req_len,
  input  logic [N_REGIONS-1:0]         s_req_last,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output logic [PADDR_W-1:0]           m_req_paddr,
  output logic [LEN_W-1:0]             m_req_len,
  output logic                         m_req_last,
  output logic [ID_W-1:0]              m_req_id,
  input  logic                         s_done_valid,
  output logic [N_REGIONS-1:0]         m_done_valid,
  output logic [CNT_W-1:0]             outstanding,
  output logic                         err_orphan_done
);

  localparam int AW = $clog2(N_OUTSTANDING);
  localparam int SW = ID_W + 1;

  logic [PADDR_W-1:0] paddr_a [N_REGIONS];
  logic [LEN_W-1:0]   len_a   [N_REGIONS];

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_unpack
    assign paddr_a[g] = s_req_paddr[g*PADDR_W +: PADDR_W];
    assign len_a[g]   = s_req_len[g*LEN_W +: LEN_W];
  end

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] rr_next;
  logic [SW-1:0]   sum;
  logic            found;
  logic            push;
  logic            pop;
  logic            can_load;
  logic            fifo_empty;
  logic            fifo_full;

  logic [ID_W-1:0] tag_mem [N_OUTSTANDING];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [ID_W-1:0] head_id;

`ifdef ARB_PACKET_LOCK_EN
  logic            lock_q;
  logic [ID_W-1:0] lock_id;
`endif

  assign fifo_empty = (outstanding == '0);
  assign fifo_full  = (outstanding == CNT_W'(N_OUTSTANDING));
  assign pop        = s_done_valid && !fifo_empty;
  assign can_load   = !m_req_valid || m_req_ready;
  assign head_id    = tag_mem[rd_ptr];

  // First valid region at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < N_REGIONS; k++) begin
      sum = SW'(rr_ptr) + SW'(k);
      if (sum >= SW'(N_REGIONS)) begin
        sum = sum - SW'(N_REGIONS);
      end
      if (!found && s_req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        win   = sum[ID_W-1:0];
      end
    end
`ifdef ARB_PACKET_LOCK_EN
    if (lock_q) begin
      found = s_req_valid[lock_id];
      win   = lock_id;
    end
`endif
  end

  // A pop in the same cycle frees the entry a full FIFO needs.
  assign push = found && can_load && (!fifo_full || pop);

  always_comb begin
    s_req_ready = '0;
    if (push) begin
      s_req_ready[win] = 1'b1;
    end
  end

  assign rr_next = (win == ID_W'(N_REGIONS - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_req_valid <= 1'b0;
      m_req_paddr <= '0;
      m_req_len   <= '0;
      m_req_last  <= 1'b0;
      m_req_id    <= '0;
    end else if (push) begin
      m_req_valid <= 1'b1;
      m_req_paddr <= paddr_a[win];
      m_req_len   <= len_a[win];
      m_req_last  <= s_req_last[win];
      m_req_id    <= win;
    end else if (m_req_ready) begin
      m_req_valid <= 1'b0;
    end
  end

`ifdef ARB_PACKET_LOCK_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr  <= '0;
      lock_q  <= 1'b0;
      lock_id <= '0;
    end else if (push) begin
      lock_q  <= !s_req_last[win];
      lock_id <= win;
      if (s_req_last[win]) begin
        rr_ptr <= rr_next;
      end
    end
  end
`else
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= rr_next;
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        push && !pop: outstanding <= outstanding + 1'b1;
        pop && !push: outstanding <= outstanding - 1'b1;
        default:      outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      tag_mem[wr_ptr] <= win;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_done_valid    <= '0;
      err_orphan_done <= 1'b0;
    end else begin
      m_done_valid <= '0;
      if (pop) begin
        m_done_valid[head_id] <= 1'b1;
      end
      if (s_done_valid && fifo_empty) begin
        err_orphan_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmu_dma_region_arbiter.sv
// Directed scoreboard bench for mmu_dma_region_arbiter.
// Lock-mode steps run only when ARB_PACKET_LOCK_EN is defined.
module tb_mmu_dma_region_arbiter;

  localparam int N  = 4;
  localparam int PW = 64;
  localparam int LW = 28;

  typedef struct {
    logic [1:0]    id;
    logic [PW-1:0] paddr;
    logic [LW-1:0] len;
    logic          last;
  } req_t;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    s_req_valid;
  logic [N-1:0]    s_req_ready;
  logic [N*PW-1:0] s_req_paddr;
  logic [N*LW-1:0] s_req_len;
  logic [N-1:0]    s_req_last;
  logic            m_req_valid;
  logic            m_req_ready;
  logic [PW-1:0]   m_req_paddr;
  logic [LW-1:0]   m_req_len;
  logic            m_req_last;
  logic [1:0]      m_req_id;
  logic            s_done_valid;
  logic [N-1:0]    m_done_valid;
  logic [4:0]      outstanding;
  logic            err_orphan_done;

  mmu_dma_region_arbiter dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_req_valid     (s_req_valid),
    .s_req_ready     (s_req_ready),
    .s_req_paddr     (s_req_paddr),
    .s_req_len       (s_req_len),
    .s_req_last      (s_req_last),
    .m_req_valid     (m_req_valid),
    .m_req_ready     (m_req_ready),
    .m_req_paddr     (m_req_paddr),
    .m_req_len       (m_req_len),
    .m_req_last      (m_req_last),
    .m_req_id        (m_req_id),
    .s_done_valid    (s_done_valid),
    .m_done_valid    (m_done_valid),
    .outstanding     (outstanding),
    .err_orphan_done (err_orphan_done)
  );

  always #5 aclk = ~aclk;

  req_t          exp_req[$];
  int            tag_q[$];
  logic [PW-1:0] pad [N];
  logic [LW-1:0] ln  [N];
  logic          lst [N];
  logic [N-1:0]  done_exp;
  logic          orphan_exp;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns before posedge.
  task automatic go(input logic [N-1:0] vld, input logic rdy,
                    input logic dn, input logic [N-1:0] exp_rdy);
    req_t r;
    int   w;
    s_req_valid  = vld;
    m_req_ready  = rdy;
    s_done_valid = dn;
    for (int i = 0; i < N; i++) begin
      s_req_paddr[i*PW +: PW] = pad[i];
      s_req_len[i*LW +: LW]   = ln[i];
      s_req_last[i]           = lst[i];
    end
    #4;
    chk("s_req_ready", 64'(s_req_ready), 64'(exp_rdy));
    chk("m_done_valid", 64'(m_done_valid), 64'(done_exp));
    chk("err_orphan_done", 64'(err_orphan_done), 64'(orphan_exp));
    chk("outstanding", 64'(outstanding), 64'(tag_q.size()));
    chk("m_req_valid", 64'(m_req_valid), 64'(exp_req.size() != 0));
    if (exp_req.size() != 0) begin
      r = exp_req[0];
      chk("m_req_id", 64'(m_req_id), 64'(r.id));
      chk("m_req_paddr", m_req_paddr, r.paddr);
      chk("m_req_len", 64'(m_req_len), 64'(r.len));
      chk("m_req_last", 64'(m_req_last), 64'(r.last));
      if (rdy) void'(exp_req.pop_front());
    end
    done_exp = '0;
    if (dn) begin
      if (tag_q.size() != 0) done_exp = 4'b0001 << tag_q.pop_front();
      else orphan_exp = 1'b1;
    end
    if (exp_rdy != '0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (exp_rdy[i]) w = i;
      tag_q.push_back(w);
      r.id    = 2'(w);
      r.paddr = pad[w];
      r.len   = ln[w];
      r.last  = lst[w];
      exp_req.push_back(r);
      pad[w] = pad[w] + 64'h40;
      ln[w]  = ln[w] + 28'd1;
    end
    @(negedge aclk);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    done_exp     = '0;
    orphan_exp   = 1'b0;
    s_req_valid  = '0;
    s_req_paddr  = '0;
    s_req_len    = '0;
    s_req_last   = '0;
    m_req_ready  = 1'b0;
    s_done_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      pad[i] = (64'(i + 1) << 40) | 64'h100;
      ln[i]  = 28'(16 * (i + 1));
      lst[i] = 1'b1;
    end
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #1;
    chk("rst m_req_valid", 64'(m_req_valid), 64'd0);
    chk("rst s_req_ready", 64'(s_req_ready), 64'd0);
    chk("rst m_done_valid", 64'(m_done_valid), 64'd0);
    chk("rst err_orphan", 64'(err_orphan_done), 64'd0);
    chk("rst outstanding", 64'(outstanding), 64'd0);
    chk("rst m_req_paddr", m_req_paddr, 64'd0);
    chk("rst m_req_len", 64'(m_req_len), 64'd0);
    chk("rst m_req_id", 64'(m_req_id), 64'd0);
    chk("rst m_req_last", 64'(m_req_last), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Round robin with all regions valid
    go(4'b1111, 1'b1, 1'b0, 4'b0001);
    go(4'b1111, 1'b1, 1'b0, 4'b0010);
    go(4'b1111, 1'b1, 1'b0, 4'b0100);
    go(4'b1111, 1'b1, 1'b0, 4'b1000);
    go(4'b1111, 1'b1, 1'b0, 4'b0001);
    go(4'b1111, 1'b1, 1'b0, 4'b0010);
    go(4'b0000, 1'b1, 1'b0, 4'b0000);

    // Single region with fixed payload
    pad[2] = 64'h1000;
    ln[2]  = 28'd64;
    go(4'b0100, 1'b1, 1'b0, 4'b0100);
    go(4'b0000, 1'b1, 1'b0, 4'b0000);

    // Downstream stall
    go(4'b0011, 1'b0, 1'b0, 4'b0001);
    for (int i = 0; i < 5; i++) go(4'b0011, 1'b0, 1'b0, 4'b0000);
    go(4'b0011, 1'b1, 1'b0, 4'b0010);
    go(4'b0000, 1'b1, 1'b0, 4'b0000);
    go(4'b0000, 1'b1, 1'b0, 4'b0000);

    // Fill tag FIFO to 16, then pop-and-push while full
    for (int i = 0; i < 7; i++) go(4'b1000, 1'b1, 1'b0, 4'b1000);
    go(4'b1000, 1'b1, 1'b0, 4'b0000);
    go(4'b1000, 1'b1, 1'b1, 4'b1000);
    go(4'b1000, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 16; i++) go(4'b0000, 1'b1, 1'b1, 4'b0000);
    go(4'b0000, 1'b1, 1'b0, 4'b0000);

    // Completion routing and orphan
    go(4'b1000, 1'b1, 1'b0, 4'b1000);
    go(4'b0010, 1'b1, 1'b0, 4'b0010);
    go(4'b0001, 1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 4; i++) go(4'b0000, 1'b1, 1'b1, 4'b0000);
    go(4'b0000, 1'b1, 1'b0, 4'b0000);
    go(4'b0000, 1'b1, 1'b0, 4'b0000);

`ifdef ARB_PACKET_LOCK_EN
    lst[1] = 1'b0;
    go(4'b0011, 1'b1, 1'b0, 4'b0010);
    go(4'b0011, 1'b1, 1'b0, 4'b0010);
    lst[1] = 1'b1;
    go(4'b0011, 1'b1, 1'b0, 4'b0010);
    go(4'b0001, 1'b1, 1'b0, 4'b0001);
    go(4'b0000, 1'b1, 1'b0, 4'b0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
